// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types for the SRAM arbiter
package sram_arbiter_pkg;
  typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/rr_arb_tree_lite.sv
// rtl/rr_arb_tree_lite.sv - combinational round-robin picker
// Searches upward from ptr_i with wrap; idx_o/valid_o describe the one-hot winner.
module rr_arb_tree_lite #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin sharing of one single-port SRAM
// Zero-fills the array after reset, then grants one requester per cycle.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024,
  parameter int INIT_EN    = 1,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int BW = (DATA_WIDTH + 7) / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS-1:0]          we_i,
  input  logic [NUM_PORTS*AW-1:0]       addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS*BW-1:0]       be_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [NUM_PORTS-1:0]          rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          init_done_o,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [AW-1:0]                 sram_addr_o,
  output logic [DATA_WIDTH-1:0]         sram_wdata_o,
  output logic [BW-1:0]                 sram_be_o,
  input  logic [DATA_WIDTH-1:0]         sram_rdata_i
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
  logic                  done_q, done_d;

  logic [NUM_PORTS-1:0]  arb_gnt;
  logic [PW-1:0]         arb_idx;
  logic                  arb_valid;

  rr_arb_tree_lite #(.N(NUM_PORTS), .IW(PW)) u_arb (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    done_d       = done_q;
    rvalid_d     = '0;
    gnt_o        = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    case (state_q)
      INIT: begin
        sram_req_o  = 1'b1;
        sram_we_o   = 1'b1;
        sram_be_o   = '1;
        sram_addr_o = cnt_q;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == AW'(NUM_WORDS - 1)) begin
          state_d = RUN;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        if (arb_valid) begin
          gnt_o        = arb_gnt;
          sram_req_o   = 1'b1;
          sram_we_o    = we_i[arb_idx];
          sram_addr_o  = addr_i[int'(arb_idx)*AW +: AW];
          sram_wdata_o = wdata_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          sram_be_o    = be_i[int'(arb_idx)*BW +: BW];
          ptr_d        = (arb_idx == PW'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;
          rvalid_d     = we_i[arb_idx] ? '0 : arb_gnt;
        end
      end
    endcase
    // Nothing may reach the SRAM or a requester while reset is held.
    if (rst_i) begin
      gnt_o      = '0;
      sram_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= (INIT_EN != 0) ? INIT : RUN;
      cnt_q    <= '0;
      ptr_q    <= '0;
      rvalid_q <= '0;
      done_q   <= (INIT_EN == 0);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  assign rvalid_o    = rst_i ? '0 : rvalid_q;
  assign rdata_o     = sram_rdata_i;
  assign init_done_o = done_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter
module tb_sram_arbiter;
  localparam int NP = 3;
  localparam int DW = 32;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst0;
  logic [NP-1:0] req, req0, we;
  logic [AW-1:0] addr [NP];
  logic [DW-1:0] wdata [NP];
  logic [BW-1:0] be [NP];
  logic [NP*AW-1:0] addr_f;
  logic [NP*DW-1:0] wdata_f;
  logic [NP*BW-1:0] be_f;
  assign addr_f  = {addr[2], addr[1], addr[0]};
  assign wdata_f = {wdata[2], wdata[1], wdata[0]};
  assign be_f    = {be[2], be[1], be[0]};

  logic [NP-1:0] gnt, rvalid, gnt0, rvalid0;
  logic [DW-1:0] rdata, rdata0, sram_wdata, s0_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] zero_rdata = '0;
  logic init_done, done0, sram_req, sram_we, s0_req, s0_we;
  logic [AW-1:0] sram_addr, s0_addr;
  logic [BW-1:0] sram_be, s0_be;

  sram_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_WORDS(NW), .INIT_EN(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr_f), .wdata_i(wdata_f),
    .be_i(be_f), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .init_done_o(init_done),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  sram_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_WORDS(NW), .INIT_EN(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst0), .req_i(req0), .we_i(we), .addr_i(addr_f), .wdata_i(wdata_f),
    .be_i(be_f), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .init_done_o(done0),
    .sram_req_o(s0_req), .sram_we_o(s0_we), .sram_addr_o(s0_addr),
    .sram_wdata_o(s0_wdata), .sram_be_o(s0_be), .sram_rdata_i(zero_rdata)
  );

  // SRAM model, seeded with nonzero garbage so the zero-fill is observable
  logic [DW-1:0] mem [NW];
  logic seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < NW; i++) mem[i] <= 32'hA5A5_0000 | i;
      seeded <= 1'b1;
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct packed {
    logic [NP-1:0] v;
    logic [DW-1:0] d;
  } rsp_t;
  rsp_t q [$];
  rsp_t e;
  logic [DW-1:0] exp_mem [NW];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid !== '0) begin
      if (q.size() == 0) begin
        chk("unexpected_rvalid", {29'b0, rvalid}, 32'h0);
      end else begin
        e = q.pop_front();
        chk("rvalid", {29'b0, rvalid}, {29'b0, e.v});
        chk("rdata", rdata, e.d);
      end
    end
  end

  task automatic setp(input int k, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] b);
    we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
  endtask

  task automatic issue(input logic [NP-1:0] r, input logic [NP-1:0] eg, input string nm);
    req = r;
    @(negedge clk);
    chk(nm, {29'b0, gnt}, {29'b0, eg});
    for (int k = 0; k < NP; k++) begin
      if (eg[k]) begin
        if (we[k]) begin
          for (int b = 0; b < BW; b++)
            if (be[k][b]) exp_mem[addr[k]][8*b +: 8] = wdata[k][8*b +: 8];
        end else begin
          q.push_back({eg, exp_mem[addr[k]]});
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic init_sweep(input string nm);
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      chk({nm, "_addr"}, {28'b0, sram_addr}, i);
      chk({nm, "_ctl"}, {22'b0, sram_req, sram_we, sram_be, gnt, init_done}, {22'b0, 10'b11_1111_000_0});
      chk({nm, "_wdata"}, sram_wdata, 32'h0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < NW; i++) exp_mem[i] = '0;
  endtask

  logic [NP-1:0] rr_seq [6];

  initial begin
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rst = 1'b1; rst0 = 1'b1; req = '0; req0 = '0; we = '0;
    for (int k = 0; k < NP; k++) setp(k, 1'b0, '0, '0, '0);
    setp(0, 1'b0, 4'd3, '0, '0);
    req = 3'b001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_gnt", {29'b0, gnt}, 32'h0);
    chk("rst_sram_req", {31'b0, sram_req}, 32'h0);
    chk("rst_rvalid", {29'b0, rvalid}, 32'h0);
    chk("rst_init_done", {31'b0, init_done}, 32'h0);
    chk("dut0_rst_done", {31'b0, done0}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    init_sweep("init1");
    chk("init_done_c17", {31'b0, init_done}, 32'h1);
    issue(3'b001, 3'b001, "p0_first");

    setp(1, 1'b1, 4'd5, 32'hDEADBEEF, 4'b0011);
    issue(3'b010, 3'b010, "p1_wr");
    setp(1, 1'b0, 4'd5, '0, '0);
    issue(3'b010, 3'b010, "p1_rd");
    setp(2, 1'b0, 4'd5, '0, '0);
    issue(3'b100, 3'b100, "p2_rd");

    setp(0, 1'b0, 4'd0, '0, '0);
    setp(1, 1'b0, 4'd1, '0, '0);
    for (int j = 0; j < 6; j++) issue(3'b111, rr_seq[j], "rr3");

    issue(3'b010, 3'b010, "p1_rd2");
    issue(3'b101, 3'b100, "wrap_a");
    issue(3'b101, 3'b001, "wrap_b");
    issue(3'b101, 3'b100, "wrap_c");

    req = '0;
    @(negedge clk);
    chk("idle_gnt", {29'b0, gnt}, 32'h0);
    chk("idle_sram", {sram_req, sram_we, sram_addr, sram_be, 22'b0}, 32'h0);
    @(posedge clk); #1;

    setp(0, 1'b1, 4'd7, 32'h12345678, 4'hF);
    issue(3'b001, 3'b001, "p0_wr7");
    setp(0, 1'b0, 4'd7, '0, '0);
    req = 3'b001;
    @(negedge clk);
    chk("p0_rd7_pre_rst", {29'b0, gnt}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("rst_kill_rvalid", {29'b0, rvalid}, 32'h0);
    chk("rst_kill_gnt", {29'b0, gnt}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rvalid_after", {29'b0, rvalid}, 32'h0);
    init_sweep("init2");
    issue(3'b001, 3'b001, "p0_rd7_post");
    req = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    setp(0, 1'b1, 4'd2, 32'h0000_00AA, 4'hF);
    rst0 = 1'b0; req0 = 3'b001;
    @(negedge clk);
    chk("dut0_done", {31'b0, done0}, 32'h1);
    chk("dut0_gnt", {29'b0, gnt0}, 32'h1);
    chk("dut0_sram", {s0_req, s0_we, s0_addr, s0_be, 22'b0}, {1'b1, 1'b1, 4'd2, 4'hF, 22'b0});
    @(posedge clk); #1;
    req0 = '0;
    @(negedge clk);
    chk("dut0_no_rvalid", {29'b0, rvalid0}, 32'h0);
    chk("sb_empty", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
